// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the DSP multiply-accumulate pipeline.
// Mode encodings, default widths and a small mode-decode helper.
package dsp_mac_pkg;

  localparam int A_WIDTH_DEF = 18;
  localparam int B_WIDTH_DEF = 18;
  localparam int P_WIDTH_DEF = 48;

  localparam logic [1:0] MODE_MUL      = 2'b00;
  localparam logic [1:0] MODE_MACC_ADD = 2'b01;
  localparam logic [1:0] MODE_MACC_SUB = 2'b10;

  // Reserved encoding 2'b11 decodes as MUL because it is not an accumulate mode.
  function automatic logic is_macc(input logic [1:0] m);
    return (m == MODE_MACC_ADD) || (m == MODE_MACC_SUB);
  endfunction

endpackage

// File: rtl/dsp_mac_acc.sv
// Third pipeline stage: accumulator/output register with wrap-around
// add/subtract and sticky overflow detection.
module dsp_mac_acc
  import dsp_mac_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int SIGNED  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic               clr,
  input  logic [P_WIDTH-1:0] prod,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] acc,
  output logic               ovf
);

  logic               macc;
  logic               sub;
  logic [P_WIDTH-1:0] base;
  logic [P_WIDTH-1:0] res;
  logic [P_WIDTH:0]   sum;
  logic               ovf_s;
  logic               ovf_now;

  // MUL is handled as 0 + prod; the extra sum bit is the unsigned carry/borrow.
  always_comb begin
    macc    = is_macc(mode);
    sub     = (mode == MODE_MACC_SUB);
    base    = (clr || !macc) ? '0 : acc;
    sum     = sub ? ({1'b0, base} - {1'b0, prod}) : ({1'b0, base} + {1'b0, prod});
    res     = sum[P_WIDTH-1:0];
    ovf_s   = sub ? ((base[P_WIDTH-1] != prod[P_WIDTH-1]) && (res[P_WIDTH-1] != base[P_WIDTH-1]))
                  : ((base[P_WIDTH-1] == prod[P_WIDTH-1]) && (res[P_WIDTH-1] != base[P_WIDTH-1]));
    ovf_now = macc && ((SIGNED != 0) ? ovf_s : sum[P_WIDTH]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        acc <= res;
        ovf <= (clr || !macc) ? ovf_now : (ovf | ovf_now);
      end
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage multiply/accumulate pipeline with valid/ready handshake;
// a single global enable stalls every stage while the output is blocked.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int SIGNED  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic [1:0]         mode,
  input  logic               clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] p,
  output logic               ovf
);

  localparam int PW_PROD = A_WIDTH + B_WIDTH;

  logic               en;
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic               s1_valid;
  logic [1:0]         s1_mode;
  logic               s1_clr;
  logic [PW_PROD-1:0] ext_a;
  logic [PW_PROD-1:0] ext_b;
  logic [PW_PROD-1:0] prod_full;
  logic [P_WIDTH-1:0] prod_ext;
  logic [P_WIDTH-1:0] s2_prod;
  logic               s2_valid;
  logic [1:0]         s2_mode;
  logic               s2_clr;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_MUL;
      s1_clr   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
      s1_mode  <= mode;
      s1_clr   <= clr;
    end
  end

  // Operands are widened to the full product width so the low PW_PROD bits
  // of one multiply are correct for both signed and unsigned operation.
  always_comb begin
    ext_a     = {{B_WIDTH{(SIGNED != 0) && s1_a[A_WIDTH-1]}}, s1_a};
    ext_b     = {{A_WIDTH{(SIGNED != 0) && s1_b[B_WIDTH-1]}}, s1_b};
    prod_full = ext_a * ext_b;
    prod_ext  = {P_WIDTH{(SIGNED != 0) && prod_full[PW_PROD-1]}};
    prod_ext[PW_PROD-1:0] = prod_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_mode  <= MODE_MUL;
      s2_clr   <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= prod_ext;
      s2_mode  <= s1_mode;
      s2_clr   <= s1_clr;
    end
  end

  dsp_mac_acc #(
    .P_WIDTH(P_WIDTH),
    .SIGNED (SIGNED)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (s2_valid),
    .mode     (s2_mode),
    .clr      (s2_clr),
    .prod     (s2_prod),
    .out_valid(out_valid),
    .acc      (p),
    .ovf      (ovf)
  );

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench: three pipeline variants (signed/48, signed/36, unsigned/48)
// share one stimulus stream; each result is compared against a behavioural model.
module tb_dsp_mac_pipe;

  typedef struct {
    longint p;
    bit     ovf;
    int     acc_cyc;
    bit     chk_lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [17:0] a;
  logic [17:0] b;
  logic [1:0]  mode;
  logic        clr;
  logic [2:0]  irdy;
  logic [2:0]  ovld;
  logic [2:0]  ovfo;
  logic [47:0] p0;
  logic [35:0] p1;
  logic [47:0] p2;

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  longint acc_m[3];
  bit     ovf_m[3];
  exp_t   mon_e;
  bit     rnd_done;

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SIGNED(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .a(a), .b(b),
    .mode(mode), .clr(clr), .out_valid(ovld[0]), .out_ready(out_ready), .p(p0), .ovf(ovfo[0]));

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(36), .SIGNED(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .a(a), .b(b),
    .mode(mode), .clr(clr), .out_valid(ovld[1]), .out_ready(out_ready), .p(p1), .ovf(ovfo[1]));

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SIGNED(0)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .a(a), .b(b),
    .mode(mode), .clr(clr), .out_valid(ovld[2]), .out_ready(out_ready), .p(p2), .ovf(ovfo[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pw_of(input int i);
    return (i == 1) ? 36 : 48;
  endfunction

  function automatic bit sg_of(input int i);
    return (i != 2);
  endfunction

  function automatic logic [63:0] dut_p(input int i);
    case (i)
      0:       return 64'(p0);
      1:       return 64'(p1);
      default: return 64'(p2);
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
    end
  endtask

  // Behavioural model: exact integer arithmetic, then range test for overflow.
  task automatic push_all(input logic [17:0] av, input logic [17:0] bv, input logic [1:0] md,
                          input bit cl, input bit lat);
    for (int i = 0; i < 3; i++) begin
      int     w;
      longint lim;
      longint pt;
      longint bvv;
      longint tv;
      bit     on;
      exp_t   e;
      w   = pw_of(i);
      lim = longint'(1) << w;
      if (sg_of(i)) pt = longint'($signed(av)) * longint'($signed(bv));
      else          pt = longint'(av) * longint'(bv);
      if (!((md == 2'b01) || (md == 2'b10))) begin
        acc_m[i] = pt & (lim - 1);
        ovf_m[i] = 1'b0;
      end else begin
        bvv = cl ? 0 : acc_m[i];
        if (sg_of(i) && bvv[w-1]) bvv = bvv - lim;
        tv = (md == 2'b01) ? (bvv + pt) : (bvv - pt);
        if (sg_of(i)) on = (tv < -(lim >> 1)) || (tv >= (lim >> 1));
        else          on = (tv < 0) || (tv >= lim);
        acc_m[i] = tv & (lim - 1);
        ovf_m[i] = cl ? on : (ovf_m[i] | on);
      end
      e.p       = acc_m[i];
      e.ovf     = ovf_m[i];
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      case (i)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic applyStimulus(input int av, input int bv, input logic [1:0] md,
                               input bit cl, input bit lat);
    bit accepted;
    int n;
    accepted = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    a        = av[17:0];
    b        = bv[17:0];
    mode     = md;
    clr      = cl;
    while (!accepted && n < 100) begin
      @(negedge clk);
      if (irdy[0]) begin
        push_all(a, b, mode, clr, lat);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0)
      checkOutput("drain_timeout", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  // Output monitor: every delivered result must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int i = 0; i < 3; i++) begin
        if (ovld[i]) begin
          if (q_size(i) == 0) begin
            checkOutput($sformatf("stale_result_d%0d", i), 64'd1, 64'd0);
          end else begin
            case (i)
              0:       mon_e = q0.pop_front();
              1:       mon_e = q1.pop_front();
              default: mon_e = q2.pop_front();
            endcase
            checkOutput($sformatf("p_d%0d", i), dut_p(i), mon_e.p);
            checkOutput($sformatf("ovf_d%0d", i), 64'(ovfo[i]), 64'(mon_e.ovf));
            if (mon_e.chk_lat)
              checkOutput($sformatf("latency_d%0d", i), 64'(cyc - mon_e.acc_cyc), 64'd3);
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    mode      = 2'b00;
    clr       = 1'b0;
    rnd_done  = 1'b0;
    clear_model();

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 64'(ovld), 64'd0);
    checkOutput("reset_in_ready", 64'(irdy), 64'd7);
    checkOutput("reset_p0", 64'(p0), 64'd0);
    checkOutput("reset_ovf", 64'(ovfo), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_out_valid", 64'(ovld), 64'd0);
    checkOutput("post_reset_in_ready", 64'(irdy), 64'd7);

    $display("[TB] signed multiply -3 * 7");
    applyStimulus(-3, 7, 2'b00, 1'b0, 1'b1);
    drain();

    $display("[TB] accumulate stream 6, 26, 20");
    applyStimulus(2, 3, 2'b01, 1'b1, 1'b1);
    applyStimulus(4, 5, 2'b01, 1'b0, 1'b1);
    applyStimulus(-1, 6, 2'b01, 1'b0, 1'b1);
    drain();

    $display("[TB] backpressure during a 4-sample stream");
    fork
      begin
        applyStimulus(3, 4, 2'b01, 1'b1, 1'b0);
        applyStimulus(5, 6, 2'b01, 1'b0, 1'b0);
        applyStimulus(7, -8, 2'b10, 1'b0, 1'b0);
        applyStimulus(9, 10, 2'b01, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("bp_in_ready", 64'(irdy[0]), 64'd0);
          if (q0.size() != 0) checkOutput("bp_p_hold", 64'(p0), q0[0].p);
          else checkOutput("bp_pending", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] overflow on repeated 131071 * 131071");
    applyStimulus(131071, 131071, 2'b01, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(131071, 131071, 2'b01, 1'b0, 1'b0);
    applyStimulus(131071, 131071, 2'b01, 1'b1, 1'b0);
    applyStimulus(2, 2, 2'b00, 1'b0, 1'b0);
    drain();

    $display("[TB] subtract stream 100, 99, wrap");
    applyStimulus(10, 10, 2'b01, 1'b1, 1'b0);
    applyStimulus(1, 1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1, 200, 2'b10, 1'b0, 1'b0);
    applyStimulus(5, -2, 2'b11, 1'b0, 1'b0);
    drain();

    $display("[TB] reset with samples in flight");
    applyStimulus(11, 12, 2'b01, 1'b1, 1'b0);
    applyStimulus(13, 14, 2'b01, 1'b0, 1'b0);
    applyStimulus(15, 16, 2'b01, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(ovld), 64'd0);
    checkOutput("midreset_p0", 64'(p0), 64'd0);
    checkOutput("midreset_p2", 64'(p2), 64'd0);
    clear_model();
    repeat (2) @(negedge clk);
    checkOutput("midreset_in_ready", 64'(irdy), 64'd7);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_first_cycle", 64'(ovld), 64'd0);
    idle(6);

    $display("[TB] accumulate without clr after reset");
    applyStimulus(4, 4, 2'b01, 1'b0, 1'b1);
    applyStimulus(-2, 3, 2'b10, 1'b0, 1'b1);
    drain();

    $display("[TB] random traffic with random backpressure");
    fork
      begin
        for (int k = 0; k < 60; k++)
          applyStimulus(int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                        2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameter A_WIDTH, default 18: operand A width in bits.
REQ-002 Parameter B_WIDTH, default 18: operand B width in bits.
REQ-003 Parameter P_WIDTH, default 48: accumulator/result width, SHALL be >= A_WIDTH+B_WIDTH.
REQ-004 Parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  sample present on a, b, mode, clr.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 a  input  A_WIDTH  operand A.
REQ-010 b  input  B_WIDTH  operand B.
REQ-011 mode  input  2  00 MUL, 01 MACC_ADD, 10 MACC_SUB, 11 reserved (treated as MUL).
REQ-012 clr  input  1  sample starts a new accumulation (accumulator loaded, not added).
REQ-013 out_valid  output  1  result present on p.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 p  output  P_WIDTH  result.
REQ-016 ovf  output  1  sticky accumulator overflow flag.

Function
REQ-017 A sample SHALL be accepted when in_valid && in_ready; a result SHALL be delivered when out_valid && out_ready.
REQ-018 The pipeline SHALL have three register stages (S1 input regs, S2 product reg, S3 accumulator/output reg); a sample accepted at cycle N SHALL give out_valid at cycle N+3 with no stall.
REQ-019 The global enable SHALL be en = !(out_valid && !out_ready); in_ready SHALL equal en; all stage registers SHALL hold when en is 0.
REQ-020 Each stage SHALL carry valid, mode and clr alongside data; bubbles SHALL propagate as valid=0 and SHALL NOT modify the accumulator.
REQ-021 S2 SHALL compute the full A_WIDTH+B_WIDTH product, sign- or zero-extended to P_WIDTH per SIGNED.
REQ-022 S3 on a valid sample: MUL -> acc = prod; MACC_ADD -> acc = (clr ? 0 : acc) + prod; MACC_SUB -> acc = (clr ? 0 : acc) - prod; arithmetic SHALL wrap modulo 2^P_WIDTH.
REQ-023 p SHALL equal the S3 accumulator register; p SHALL hold its value while out_valid && !out_ready.
REQ-024 ovf SHALL set when a MACC_ADD/MACC_SUB update overflows P_WIDTH (signed: operand signs agree and result sign differs; unsigned: carry/borrow out); it SHALL clear on any valid S3 sample with clr=1 or mode=MUL, which itself SHALL then re-evaluate overflow for that sample only.
REQ-025 Simultaneous out_ready rising and new input SHALL accept the input in that cycle with no lost or duplicated result.
REQ-026 A MACC sample without clr after reset SHALL accumulate onto 0.

Reset
REQ-027 rst SHALL asynchronously clear all stage valids, the accumulator, p, and ovf to 0; out_valid SHALL be 0 and in_ready SHALL be 1 while rst is high and in the first cycle after.
REQ-028 Reset mid-operation SHALL discard all in-flight samples; no result from before reset SHALL appear after it.

Structure
REQ-029 Shared package dsp_mac_pkg SHALL hold the mode encodings (MODE_MUL, MODE_MACC_ADD, MODE_MACC_SUB) and the default width constants.
REQ-030 Sub-module dsp_mac_acc SHALL implement S3 (accumulate/subtract, wrap, overflow detection); the top SHALL hold S1, S2 and the handshake.
REQ-031 The multiply SHALL be written to infer one DSP48E1 at default widths.

Verification
REQ-032 MUL, SIGNED=1: a=-3, b=7, out_ready=1 -> p=-21 exactly 3 cycles after acceptance, ovf=0.
REQ-033 MACC_ADD stream (2,3,clr=1),(4,5),(-1,6) -> p sequence 6, 26, 20 on consecutive cycles.
REQ-034 Backpressure: out_ready=0 for 5 cycles during a 4-sample stream -> in_ready drops, p holds, all 4 results appear in order with no loss or duplication.
REQ-035 Overflow: P_WIDTH=36, MACC_ADD with a=b=131071 repeated, clr on first -> ovf sets on the first wrapping update and stays set until a clr sample.
REQ-036 Assert rst with 3 samples in flight -> out_valid=0 immediately, p=0, no stale result after release.
REQ-037 SIGNED=0, MACC_SUB: (10,10,clr=1),(1,1) -> p=100 then 99; then (1,200) -> p wraps modulo 2^48, ovf=1.
